// File: rtl/operand_result_mem.sv
// Operand/result store for the matrix-compute datapath.
// Captures A/B operands in one cycle, collects per-engine result tiles, serves registered reads.
module operand_result_mem #(
    parameter int DATA_W  = 8,
    parameter int A_DIM   = 4,
    parameter int B_DIM   = 3,
    parameter int C_DIM   = 2,
    parameter int NUM_SRC = 3,
    localparam int A_SZ      = A_DIM * A_DIM,
    localparam int B_SZ      = B_DIM * B_DIM,
    localparam int C_SZ      = C_DIM * C_DIM,
    localparam int AB_DEPTH  = A_SZ + B_SZ,
    localparam int AB_AW     = $clog2(AB_DEPTH),
    localparam int RES_DEPTH = NUM_SRC * C_SZ,
    localparam int RES_AW    = $clog2(RES_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     run_valid_i,
    input  logic                     clear_i,
    input  logic [A_SZ*DATA_W-1:0]   a_flat_i,
    input  logic [B_SZ*DATA_W-1:0]   b_flat_i,
    input  logic [C_SZ*DATA_W-1:0]   c_flat_i,
    input  logic [NUM_SRC-1:0]       res_valid_i,
    output logic [NUM_SRC-1:0]       res_ready_o,
    output logic                     done_capture_o,
    output logic [NUM_SRC-1:0]       slot_valid_o,
    input  logic [AB_AW-1:0]         addr_core_i,
    output logic [DATA_W-1:0]        data_core_o,
    input  logic [RES_AW-1:0]        addr_display_i,
    output logic [DATA_W-1:0]        data_display_o
);

    logic [DATA_W-1:0]  ab_mem  [AB_DEPTH];
    logic [DATA_W-1:0]  res_mem [RES_DEPTH];
    logic [NUM_SRC-1:0] grant;
    logic               found;
    logic               core_in_range;
    logic               disp_in_range;

    // Address range checks; depth always fits in one extra address bit.
    assign core_in_range = {1'b0, addr_core_i} < AB_DEPTH[AB_AW:0];
    assign disp_in_range = {1'b0, addr_display_i} < RES_DEPTH[RES_AW:0];

    // Fixed-priority grant, lowest index wins; no grant while in reset.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (res_valid_i[k] && !found) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
        if (!reset_n) begin
            grant = '0;
        end
    end

    assign res_ready_o = grant;

    // Operand capture: all A and B elements written on a single run strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < AB_DEPTH; i++) begin
                ab_mem[i] <= '0;
            end
        end else if (run_valid_i) begin
            for (int i = 0; i < A_SZ; i++) begin
                ab_mem[i] <= a_flat_i[i*DATA_W +: DATA_W];
            end
            for (int j = 0; j < B_SZ; j++) begin
                ab_mem[A_SZ+j] <= b_flat_i[j*DATA_W +: DATA_W];
            end
        end
    end

    // Result tile write into the slot owned by the granted engine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                res_mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (grant[k]) begin
                    for (int e = 0; e < C_SZ; e++) begin
                        res_mem[k*C_SZ+e] <= c_flat_i[e*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Capture flag: a run strobe outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_capture_o <= 1'b0;
        end else if (run_valid_i) begin
            done_capture_o <= 1'b1;
        end else if (clear_i) begin
            done_capture_o <= 1'b0;
        end
    end

    // Slot-valid mask: a same-cycle grant sets its bit even during clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid_o <= '0;
        end else if (clear_i) begin
            slot_valid_o <= grant;
        end else begin
            slot_valid_o <= slot_valid_o | grant;
        end
    end

    // Registered read-old ports; out-of-range addresses return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_core_o    <= '0;
            data_display_o <= '0;
        end else begin
            data_core_o    <= core_in_range ? ab_mem[addr_core_i] : '0;
            data_display_o <= disp_in_range ? res_mem[addr_display_i] : '0;
        end
    end

endmodule

// File: tb/tb_operand_result_mem.sv
// Directed self-checking bench for operand_result_mem.
// Each task drives one scenario and checks its own expectations inline.
module tb_operand_result_mem;

    localparam int DATA_W  = 8;
    localparam int A_DIM   = 4;
    localparam int B_DIM   = 3;
    localparam int C_DIM   = 2;
    localparam int NUM_SRC = 3;
    localparam int A_SZ    = A_DIM * A_DIM;
    localparam int B_SZ    = B_DIM * B_DIM;
    localparam int C_SZ    = C_DIM * C_DIM;
    localparam int AB_AW   = 5;
    localparam int RES_AW  = 4;

    logic                    clk;
    logic                    reset_n;
    logic                    run_valid_i;
    logic                    clear_i;
    logic [A_SZ*DATA_W-1:0]  a_flat_i;
    logic [B_SZ*DATA_W-1:0]  b_flat_i;
    logic [C_SZ*DATA_W-1:0]  c_flat_i;
    logic [NUM_SRC-1:0]      res_valid_i;
    logic [NUM_SRC-1:0]      res_ready_o;
    logic                    done_capture_o;
    logic [NUM_SRC-1:0]      slot_valid_o;
    logic [AB_AW-1:0]        addr_core_i;
    logic [DATA_W-1:0]       data_core_o;
    logic [RES_AW-1:0]       addr_display_i;
    logic [DATA_W-1:0]       data_display_o;

    int tests;
    int fails;

    operand_result_mem #(
        .DATA_W (DATA_W),
        .A_DIM  (A_DIM),
        .B_DIM  (B_DIM),
        .C_DIM  (C_DIM),
        .NUM_SRC(NUM_SRC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run_valid_i   (run_valid_i),
        .clear_i       (clear_i),
        .a_flat_i      (a_flat_i),
        .b_flat_i      (b_flat_i),
        .c_flat_i      (c_flat_i),
        .res_valid_i   (res_valid_i),
        .res_ready_o   (res_ready_o),
        .done_capture_o(done_capture_o),
        .slot_valid_o  (slot_valid_o),
        .addr_core_i   (addr_core_i),
        .data_core_o   (data_core_o),
        .addr_display_i(addr_display_i),
        .data_display_o(data_display_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_core(input logic [AB_AW-1:0] a, output logic [DATA_W-1:0] d);
        addr_core_i = a;
        tick();
        d = data_core_o;
    endtask

    task automatic rd_disp(input logic [RES_AW-1:0] a, output logic [DATA_W-1:0] d);
        addr_display_i = a;
        tick();
        d = data_display_o;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] d;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 25; i++) begin
            rd_core(AB_AW'(i), d);
            tests++;
            if (d !== 8'h00) begin
                fails++;
                $display("FAIL reset_core[%0d] got %h want 00", i, d);
            end
        end
        for (int i = 0; i < 12; i++) begin
            rd_disp(RES_AW'(i), d);
            tests++;
            if (d !== 8'h00) begin
                fails++;
                $display("FAIL reset_disp[%0d] got %h want 00", i, d);
            end
        end
        tests++;
        if (done_capture_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_done got %b want 0", done_capture_o);
        end
        tests++;
        if (slot_valid_o !== 3'b000) begin
            fails++;
            $display("FAIL reset_slot got %b want 000", slot_valid_o);
        end
        tests++;
        if (res_ready_o !== 3'b000) begin
            fails++;
            $display("FAIL reset_ready got %b want 000", res_ready_o);
        end
    endtask

    task automatic test_capture();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < A_SZ; i++) a_flat_i[i*8 +: 8] = 8'(i + 1);
        for (int j = 0; j < B_SZ; j++) b_flat_i[j*8 +: 8] = 8'(8'h80 + j);
        run_valid_i = 1'b1;
        tick();
        run_valid_i = 1'b0;
        tests++;
        if (done_capture_o !== 1'b1) begin
            fails++;
            $display("FAIL cap_done got %b want 1", done_capture_o);
        end
        rd_core(5'd5, d);
        tests++;
        if (d !== 8'h06) begin
            fails++;
            $display("FAIL cap_a5 got %h want 06", d);
        end
        rd_core(5'd16, d);
        tests++;
        if (d !== 8'h80) begin
            fails++;
            $display("FAIL cap_b0 got %h want 80", d);
        end
        rd_core(5'd24, d);
        tests++;
        if (d !== 8'h88) begin
            fails++;
            $display("FAIL cap_b8 got %h want 88", d);
        end
        rd_core(5'd30, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL cap_oor got %h want 00", d);
        end
    endtask

    task automatic test_arbitration();
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        c_flat_i = {8'h44, 8'h33, 8'h22, 8'h11};
        res_valid_i = 3'b110;
        #1;
        tests++;
        if (res_ready_o !== 3'b010) begin
            fails++;
            $display("FAIL arb_ready1 got %b want 010", res_ready_o);
        end
        tick();
        res_valid_i = 3'b100;
        #1;
        tests++;
        if (res_ready_o !== 3'b100) begin
            fails++;
            $display("FAIL arb_ready2 got %b want 100", res_ready_o);
        end
        tests++;
        if (slot_valid_o !== 3'b010) begin
            fails++;
            $display("FAIL arb_slot1 got %b want 010", slot_valid_o);
        end
        tick();
        res_valid_i = 3'b000;
        tests++;
        if (slot_valid_o !== 3'b110) begin
            fails++;
            $display("FAIL arb_slot2 got %b want 110", slot_valid_o);
        end
        for (int i = 0; i < 8; i++) begin
            rd_disp(RES_AW'(4 + i), d);
            tests++;
            if (d !== exp[i%4]) begin
                fails++;
                $display("FAIL arb_disp[%0d] got %h want %h", 4 + i, d, exp[i%4]);
            end
        end
        rd_disp(4'd0, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL arb_slot0 got %h want 00", d);
        end
        rd_disp(4'd13, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL arb_disp_oor got %h want 00", d);
        end
    endtask

    task automatic test_clear_priority();
        logic [DATA_W-1:0] d;
        for (int j = 0; j < B_SZ; j++) b_flat_i[j*8 +: 8] = 8'(8'hC0 + j);
        c_flat_i = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        clear_i = 1'b1;
        run_valid_i = 1'b1;
        res_valid_i = 3'b001;
        #1;
        tests++;
        if (res_ready_o !== 3'b001) begin
            fails++;
            $display("FAIL clr_ready got %b want 001", res_ready_o);
        end
        tick();
        clear_i = 1'b0;
        run_valid_i = 1'b0;
        res_valid_i = 3'b000;
        tests++;
        if (done_capture_o !== 1'b1) begin
            fails++;
            $display("FAIL clr_done got %b want 1", done_capture_o);
        end
        tests++;
        if (slot_valid_o !== 3'b001) begin
            fails++;
            $display("FAIL clr_slot got %b want 001", slot_valid_o);
        end
        rd_core(5'd16, d);
        tests++;
        if (d !== 8'hC0) begin
            fails++;
            $display("FAIL clr_b0 got %h want c0", d);
        end
        rd_disp(4'd0, d);
        tests++;
        if (d !== 8'hAA) begin
            fails++;
            $display("FAIL clr_disp0 got %h want aa", d);
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tests++;
        if (done_capture_o !== 1'b0) begin
            fails++;
            $display("FAIL clr_only_done got %b want 0", done_capture_o);
        end
        tests++;
        if (slot_valid_o !== 3'b000) begin
            fails++;
            $display("FAIL clr_only_slot got %b want 000", slot_valid_o);
        end
        rd_disp(4'd3, d);
        tests++;
        if (d !== 8'hDD) begin
            fails++;
            $display("FAIL clr_keep got %h want dd", d);
        end
    endtask

    task automatic test_read_old();
        addr_core_i = 5'd9;
        tick();
        tests++;
        if (data_core_o !== 8'h0A) begin
            fails++;
            $display("FAIL rold_pre got %h want 0a", data_core_o);
        end
        a_flat_i[9*8 +: 8] = 8'hFF;
        run_valid_i = 1'b1;
        tick();
        run_valid_i = 1'b0;
        tests++;
        if (data_core_o !== 8'h0A) begin
            fails++;
            $display("FAIL rold_old got %h want 0a", data_core_o);
        end
        tick();
        tests++;
        if (data_core_o !== 8'hFF) begin
            fails++;
            $display("FAIL rold_new got %h want ff", data_core_o);
        end
    endtask

    task automatic test_async_reset();
        logic [DATA_W-1:0] d;
        addr_display_i = 4'd0;
        c_flat_i = {8'h5D, 8'h5C, 8'h5B, 8'h5A};
        res_valid_i = 3'b001;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (data_core_o !== 8'h00 || data_display_o !== 8'h00) begin
            fails++;
            $display("FAIL ares_data got %h/%h want 00/00", data_core_o, data_display_o);
        end
        tests++;
        if (done_capture_o !== 1'b0 || slot_valid_o !== 3'b000 || res_ready_o !== 3'b000) begin
            fails++;
            $display("FAIL ares_flags got %b/%b/%b want 0/000/000",
                     done_capture_o, slot_valid_o, res_ready_o);
        end
        res_valid_i = 3'b000;
        #3;
        reset_n = 1'b1;
        rd_disp(4'd0, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL ares_slot0 got %h want 00", d);
        end
        rd_core(5'd9, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL ares_core9 got %h want 00", d);
        end
        res_valid_i = 3'b001;
        tick();
        res_valid_i = 3'b000;
        tests++;
        if (slot_valid_o !== 3'b001) begin
            fails++;
            $display("FAIL ares_regrant got %b want 001", slot_valid_o);
        end
        rd_disp(4'd2, d);
        tests++;
        if (d !== 8'h5C) begin
            fails++;
            $display("FAIL ares_disp2 got %h want 5c", d);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b1;
        run_valid_i = 1'b0;
        clear_i = 1'b0;
        a_flat_i = '0;
        b_flat_i = '0;
        c_flat_i = '0;
        res_valid_i = '0;
        addr_core_i = '0;
        addr_display_i = '0;
        #2;
        test_reset();
        test_capture();
        test_arbitration();
        test_clear_priority();
        test_read_old();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
